// File: rtl/bpf_sched_pkg.sv
// Shared types for the packet buffer scheduler.
// Holds the per-buffer state encoding and the buffer-count limit.
package bpf_sched_pkg;

    localparam int MAX_BUFS = 4;
    localparam int MIN_BUFS = 2;

    typedef enum logic [2:0] {
        ST_FREE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_READY = 3'd2,
        ST_PROC  = 3'd3,
        ST_FWD   = 3'd4
    } buf_st_e;

    function automatic bit bufs_ok(int n);
        return (n >= MIN_BUFS) && (n <= MAX_BUFS);
    endfunction

endpackage

// File: rtl/idx_fifo.sv
// Register FIFO of {buffer index, packet length}; push+pop in one cycle ok.
// Ports: clk, rst, push/push_idx/push_len in, pop in, vld/head_idx/head_len out.
module idx_fifo #(
    parameter int DEPTH = 3,
    parameter int IW    = 2,
    parameter int LW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [IW-1:0] push_idx,
    input  logic [LW-1:0] push_len,
    input  logic          pop,
    output logic          vld,
    output logic [IW-1:0] head_idx,
    output logic [LW-1:0] head_len
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [PW:0]   FULL = (PW + 1)'(DEPTH);

    logic [IW-1:0] idx_q [DEPTH];
    logic [IW-1:0] idx_d [DEPTH];
    logic [LW-1:0] len_q [DEPTH];
    logic [LW-1:0] len_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          pop_ok;
    logic          push_ok;

    function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        idx_d   = idx_q;
        len_d   = len_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        pop_ok  = pop & (cnt_q != '0);
        // A full FIFO still takes a push when the head leaves together.
        push_ok = push & ((cnt_q != FULL) | pop_ok);
        if (push_ok) begin
            idx_d[wr_q] = push_idx;
            len_d[wr_q] = push_len;
            wr_d        = nxt(wr_q);
        end
        if (pop_ok) begin
            rd_d = nxt(rd_q);
        end
        cnt_d = cnt_q + (PW + 1)'(push_ok) - (PW + 1)'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
                len_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            len_q <= len_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign vld      = (cnt_q != '0);
    assign head_idx = idx_q[rd_q];
    assign head_len = len_q[rd_q];

endmodule

// File: rtl/pkt_buf_sched.sv
// Buffer ownership scheduler: snooper fill -> CPU filter -> forward drain.
// Ports: sn_* snooper alloc/done, cpu_* dispatch + acc/rej, fwd_* drain, err.
module pkt_buf_sched
    import bpf_sched_pkg::*;
#(
    parameter int NUM_BUFS  = 3,
    parameter int IDX_WIDTH = 2,
    parameter int LEN_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 sn_rdy,
    output logic [IDX_WIDTH-1:0] sn_buf,
    input  logic                 sn_done,
    input  logic [LEN_WIDTH-1:0] sn_len,
    output logic                 cpu_start,
    output logic [IDX_WIDTH-1:0] cpu_buf,
    output logic [LEN_WIDTH-1:0] cpu_len,
    input  logic                 acc,
    input  logic                 rej,
    output logic                 fwd_vld,
    output logic [IDX_WIDTH-1:0] fwd_buf,
    output logic [LEN_WIDTH-1:0] fwd_len,
    input  logic                 fwd_done,
    output logic                 err
);

    if (!bufs_ok(NUM_BUFS)) begin : g_bad_bufs
        $error("pkt_buf_sched: NUM_BUFS must be 2..4");
    end

    buf_st_e st_q [NUM_BUFS];
    buf_st_e st_d [NUM_BUFS];

    logic                 sn_rdy_q, sn_rdy_d;
    logic [IDX_WIDTH-1:0] sn_buf_q, sn_buf_d;
    logic                 cpu_start_q, cpu_start_d;
    logic [IDX_WIDTH-1:0] cpu_buf_q, cpu_buf_d;
    logic [LEN_WIDTH-1:0] cpu_len_q, cpu_len_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 rq_push, rq_pop, rq_vld;
    logic [IDX_WIDTH-1:0] rq_idx;
    logic [LEN_WIDTH-1:0] rq_len;
    logic                 fq_push, fq_pop, fq_vld;
    logic [IDX_WIDTH-1:0] fq_idx;
    logic [LEN_WIDTH-1:0] fq_len;

    logic                 sn_ok, sn_fill, cpu_ok, cpu_idle, bypass;
    logic                 free_vld;
    logic [IDX_WIDTH-1:0] free_idx;

    always_comb begin
        st_d        = st_q;
        sn_rdy_d    = sn_rdy_q;
        sn_buf_d    = sn_buf_q;
        cpu_start_d = 1'b0;
        cpu_buf_d   = cpu_buf_q;
        cpu_len_d   = cpu_len_q;
        busy_d      = busy_q;

        sn_ok   = sn_done & sn_rdy_q;
        sn_fill = sn_ok & (sn_len != '0);
        cpu_ok  = busy_q & (acc | rej);
        fq_pop  = fwd_done & fq_vld;
        fq_push = cpu_ok & acc & ~rej;

        err_d = err_q
              | (sn_done & ~sn_rdy_q)
              | ((acc | rej) & ~busy_q)
              | (acc & rej)
              | (fwd_done & ~fq_vld);

        if (sn_ok) begin
            st_d[sn_buf_q] = sn_fill ? ST_READY : ST_FREE;
            sn_rdy_d       = 1'b0;
        end

        if (fq_pop) begin
            st_d[fq_idx] = ST_FREE;
        end

        if (cpu_ok) begin
            st_d[cpu_buf_q] = fq_push ? ST_FWD : ST_FREE;
            busy_d          = 1'b0;
        end

        // Fresh fill goes straight to an idle CPU when nothing is queued,
        // so sn_done -> cpu_start takes one cycle.
        cpu_idle = ~busy_q | cpu_ok;
        rq_pop   = cpu_idle & rq_vld;
        bypass   = cpu_idle & ~rq_vld & sn_fill;
        rq_push  = sn_fill & ~bypass;

        if (rq_pop) begin
            st_d[rq_idx] = ST_PROC;
            cpu_buf_d    = rq_idx;
            cpu_len_d    = rq_len;
        end else if (bypass) begin
            st_d[sn_buf_q] = ST_PROC;
            cpu_buf_d      = sn_buf_q;
            cpu_len_d      = sn_len;
        end
        if (rq_pop | bypass) begin
            busy_d      = 1'b1;
            cpu_start_d = 1'b1;
        end

        // Lowest-index FREE buffer after this cycle's releases.
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (st_d[i] == ST_FREE) begin
                free_vld = 1'b1;
                free_idx = IDX_WIDTH'(i);
            end
        end
        if (!sn_rdy_q && free_vld) begin
            st_d[free_idx] = ST_FILL;
            sn_rdy_d       = 1'b1;
            sn_buf_d       = free_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                st_q[i] <= ST_FREE;
            end
            sn_rdy_q    <= 1'b0;
            sn_buf_q    <= '0;
            cpu_start_q <= 1'b0;
            cpu_buf_q   <= '0;
            cpu_len_q   <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            sn_rdy_q    <= sn_rdy_d;
            sn_buf_q    <= sn_buf_d;
            cpu_start_q <= cpu_start_d;
            cpu_buf_q   <= cpu_buf_d;
            cpu_len_q   <= cpu_len_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    idx_fifo #(
        .DEPTH (NUM_BUFS),
        .IW    (IDX_WIDTH),
        .LW    (LEN_WIDTH)
    ) u_ready_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rq_push),
        .push_idx (sn_buf_q),
        .push_len (sn_len),
        .pop      (rq_pop),
        .vld      (rq_vld),
        .head_idx (rq_idx),
        .head_len (rq_len)
    );

    idx_fifo #(
        .DEPTH (NUM_BUFS),
        .IW    (IDX_WIDTH),
        .LW    (LEN_WIDTH)
    ) u_fwd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fq_push),
        .push_idx (cpu_buf_q),
        .push_len (cpu_len_q),
        .pop      (fq_pop),
        .vld      (fq_vld),
        .head_idx (fq_idx),
        .head_len (fq_len)
    );

    assign sn_rdy    = sn_rdy_q;
    assign sn_buf    = sn_buf_q;
    assign cpu_start = cpu_start_q;
    assign cpu_buf   = cpu_buf_q;
    assign cpu_len   = cpu_len_q;
    assign fwd_vld   = fq_vld;
    assign fwd_buf   = fq_idx;
    assign fwd_len   = fq_len;
    assign err       = err_q;

endmodule

// File: tb/tb_pkt_buf_sched.sv
// Directed + random bench for pkt_buf_sched against a queue-based model.
// Ports: drives every DUT input, checks every output once per cycle.
module tb_pkt_buf_sched;

    localparam int NB = 3;
    localparam int IW = 2;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          sn_rdy;
    logic [IW-1:0] sn_buf;
    logic          sn_done;
    logic [LW-1:0] sn_len;
    logic          cpu_start;
    logic [IW-1:0] cpu_buf;
    logic [LW-1:0] cpu_len;
    logic          acc;
    logic          rej;
    logic          fwd_vld;
    logic [IW-1:0] fwd_buf;
    logic [LW-1:0] fwd_len;
    logic          fwd_done;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pkt_buf_sched #(
        .NUM_BUFS  (NB),
        .IDX_WIDTH (IW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sn_rdy    (sn_rdy),
        .sn_buf    (sn_buf),
        .sn_done   (sn_done),
        .sn_len    (sn_len),
        .cpu_start (cpu_start),
        .cpu_buf   (cpu_buf),
        .cpu_len   (cpu_len),
        .acc       (acc),
        .rej       (rej),
        .fwd_vld   (fwd_vld),
        .fwd_buf   (fwd_buf),
        .fwd_len   (fwd_len),
        .fwd_done  (fwd_done),
        .err       (err)
    );

    // Reference model: who owns what, kept as plain queues and flags.
    bit m_snr;
    int m_snb;
    bit m_busy;
    int m_cb;
    int m_cl;
    bit m_cs;
    bit m_err;
    bit fr [NB];
    int lens [NB];
    int rq [$];
    int fq [$];

    function automatic void m_reset();
        m_snr  = 0;
        m_snb  = 0;
        m_busy = 0;
        m_cb   = 0;
        m_cl   = 0;
        m_cs   = 0;
        m_err  = 0;
        for (int i = 0; i < NB; i++) begin
            fr[i]   = 1;
            lens[i] = 0;
        end
        rq.delete();
        fq.delete();
    endfunction

    function automatic void m_step(bit sd, int sl, bit a, bit r, bit fd);
        bit held;
        bit fv;
        held = m_snr;
        fv   = (fq.size() != 0);
        m_cs = 0;
        if (sd && !held) m_err = 1;
        if ((a || r) && !m_busy) m_err = 1;
        if (a && r) m_err = 1;
        if (fd && !fv) m_err = 1;
        if (sd && held) begin
            if (sl == 0) fr[m_snb] = 1;
            else begin
                lens[m_snb] = sl;
                rq.push_back(m_snb);
            end
            m_snr = 0;
        end
        if (fd && fv) fr[fq.pop_front()] = 1;
        if (m_busy && (a || r)) begin
            if (a && !r) fq.push_back(m_cb);
            else fr[m_cb] = 1;
            m_busy = 0;
        end
        if (!m_busy && rq.size() > 0) begin
            m_cb   = rq.pop_front();
            m_cl   = lens[m_cb];
            m_busy = 1;
            m_cs   = 1;
        end
        if (!held) begin
            for (int i = 0; i < NB; i++) begin
                if (fr[i] && !m_snr) begin
                    fr[i] = 0;
                    m_snr = 1;
                    m_snb = i;
                end
            end
        end
    endfunction

    task automatic chk(string tag, int obs, int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sn_rdy", int'(sn_rdy), int'(m_snr));
        chk("sn_buf", int'(sn_buf), m_snb);
        chk("cpu_start", int'(cpu_start), int'(m_cs));
        chk("cpu_buf", int'(cpu_buf), m_cb);
        chk("cpu_len", int'(cpu_len), m_cl);
        chk("fwd_vld", int'(fwd_vld), int'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("fwd_buf", int'(fwd_buf), fq[0]);
            chk("fwd_len", int'(fwd_len), lens[fq[0]]);
        end
        chk("err", int'(err), int'(m_err));
    endtask

    task automatic step(bit sd, int sl, bit a, bit r, bit fd);
        sn_done  = sd;
        sn_len   = LW'(sl);
        acc      = a;
        rej      = r;
        fwd_done = fd;
        @(posedge clk);
        m_step(sd, sl, a, r, fd);
        @(negedge clk);
        sn_done  = 0;
        sn_len   = '0;
        acc      = 0;
        rej      = 0;
        fwd_done = 0;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_sn_rdy"}, int'(sn_rdy), 0);
        chk({tag, "_sn_buf"}, int'(sn_buf), 0);
        chk({tag, "_cpu_start"}, int'(cpu_start), 0);
        chk({tag, "_cpu_buf"}, int'(cpu_buf), 0);
        chk({tag, "_cpu_len"}, int'(cpu_len), 0);
        chk({tag, "_fwd_vld"}, int'(fwd_vld), 0);
        chk({tag, "_fwd_buf"}, int'(fwd_buf), 0);
        chk({tag, "_fwd_len"}, int'(fwd_len), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    // Reset from a negedge, check outputs clear asynchronously,
    // release, and take the first allocation cycle.
    task automatic do_reset(string tag);
        rst = 1;
        #1;
        check_zero(tag);
        @(negedge clk);
        rst = 0;
        m_reset();
        idle();
        chk({tag, "_first_rdy"}, int'(sn_rdy), 1);
        chk({tag, "_first_buf"}, int'(sn_buf), 0);
    endtask

    initial begin
        bit sd;
        bit a;
        bit r;
        bit fd;
        int sl;
        int k;

        rst      = 1;
        sn_done  = 0;
        sn_len   = '0;
        acc      = 0;
        rej      = 0;
        fwd_done = 0;
        m_reset();
        repeat (2) @(negedge clk);
        do_reset("rst0");

        // Accept path.
        step(1, 64, 0, 0, 0);
        chk("acc_cpu_start", int'(cpu_start), 1);
        chk("acc_cpu_buf", int'(cpu_buf), 0);
        chk("acc_cpu_len", int'(cpu_len), 64);
        repeat (4) idle();
        step(0, 0, 1, 0, 0);
        chk("acc_fwd_vld", int'(fwd_vld), 1);
        chk("acc_fwd_buf", int'(fwd_buf), 0);
        chk("acc_fwd_len", int'(fwd_len), 64);
        step(0, 0, 0, 0, 1);
        chk("acc_fwd_drained", int'(fwd_vld), 0);

        // Full / order.
        do_reset("rst1");
        step(1, 10, 0, 0, 0);
        chk("full_first_buf", int'(cpu_buf), 0);
        idle();
        step(1, 20, 0, 0, 0);
        idle();
        step(1, 30, 0, 0, 0);
        idle();
        chk("full_sn_rdy", int'(sn_rdy), 0);
        step(0, 0, 0, 1, 0);
        chk("order_buf1", int'(cpu_buf), 1);
        chk("order_realloc_rdy", int'(sn_rdy), 1);
        chk("order_realloc_buf", int'(sn_buf), 0);
        step(0, 0, 0, 1, 0);
        chk("order_buf2", int'(cpu_buf), 2);
        chk("order_len2", int'(cpu_len), 30);
        step(0, 0, 0, 1, 0);

        // Zero length.
        step(1, 0, 0, 0, 0);
        chk("zero_no_start", int'(cpu_start), 0);
        idle();
        chk("zero_realloc_rdy", int'(sn_rdy), 1);
        chk("zero_realloc_buf", int'(sn_buf), 0);

        // Protocol errors.
        step(1, 5, 0, 0, 0);
        idle();
        step(0, 0, 1, 1, 0);
        chk("both_err", int'(err), 1);
        chk("both_no_fwd", int'(fwd_vld), 0);
        step(0, 0, 0, 0, 1);
        chk("fd_err_sticky", int'(err), 1);
        chk("fd_no_fwd", int'(fwd_vld), 0);

        // Concurrent events, then reset mid-PROC.
        do_reset("rst2");
        step(1, 100, 0, 0, 0);
        idle();
        step(0, 0, 1, 0, 0);
        step(1, 200, 0, 0, 0);
        idle();
        step(1, 300, 1, 0, 1);
        chk("conc_cpu_start", int'(cpu_start), 1);
        chk("conc_cpu_buf", int'(cpu_buf), 2);
        chk("conc_cpu_len", int'(cpu_len), 300);
        chk("conc_fwd_buf", int'(fwd_buf), 1);
        chk("conc_fwd_len", int'(fwd_len), 200);
        chk("conc_sn_rdy", int'(sn_rdy), 0);
        chk("conc_err", int'(err), 0);
        do_reset("rst3");

        // Random traffic, mostly protocol-clean.
        for (int n = 0; n < 400; n++) begin
            sd = m_snr && ($urandom_range(0, 2) == 0);
            sl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4095));
            k  = int'($urandom_range(0, 3));
            a  = m_busy && (k == 0);
            r  = m_busy && (k == 1);
            fd = (fq.size() != 0) && ($urandom_range(0, 1) == 0);
            if (n > 300 && $urandom_range(0, 49) == 0) fd = 1;
            step(sd, sl, a, r, fd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
